// File: rtl/axil2iob.sv
// AXI4-lite slave to native (IOb) master bridge: one native access per AXI
// transaction, a single transaction in flight, responses always OKAY.
module axil2iob #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     S_AXI_AWADDR,
  input  logic [2:0]            S_AXI_AWPROT,
  input  logic                  S_AXI_AWVALID,
  output logic                  S_AXI_AWREADY,
  input  logic [DATA_W-1:0]     S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]   S_AXI_WSTRB,
  input  logic                  S_AXI_WVALID,
  output logic                  S_AXI_WREADY,
  output logic [1:0]            S_AXI_BRESP,
  output logic                  S_AXI_BVALID,
  input  logic                  S_AXI_BREADY,
  input  logic [ADDR_W-1:0]     S_AXI_ARADDR,
  input  logic [2:0]            S_AXI_ARPROT,
  input  logic                  S_AXI_ARVALID,
  output logic                  S_AXI_ARREADY,
  output logic [DATA_W-1:0]     S_AXI_RDATA,
  output logic [1:0]            S_AXI_RRESP,
  output logic                  S_AXI_RVALID,
  input  logic                  S_AXI_RREADY,
  output logic                  valid,
  output logic [ADDR_W-1:0]     addr,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RRESP} state_t;

  state_t              state, state_nxt;
  logic                aw_held, w_held;
  logic                rd_last;
  logic [ADDR_W-1:0]   aw_addr_q, ar_addr_q;
  logic [DATA_W-1:0]   w_data_q, rdata_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                idle, collision, aw_hs, w_hs, ar_hs;
  logic                unused_prot;

  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;
  assign S_AXI_RDATA = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      rd_last <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (aw_hs) aw_held <= 1'b1;
      if (w_hs)  w_held  <= 1'b1;
      if (state == WR && ready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      // The winner of a collision becomes the side served last
      if (collision) rd_last <= !rd_last;
      if (state == RD && ready) rdata_q <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA;
      w_strb_q <= S_AXI_WSTRB;
    end
    if (ar_hs) ar_addr_q <= S_AXI_ARADDR;
  end

  always_comb begin
    state_nxt     = state;
    valid         = 1'b0;
    addr          = '0;
    wdata         = '0;
    wstrb         = '0;
    S_AXI_BVALID  = 1'b0;
    S_AXI_RVALID  = 1'b0;

    idle      = (state == IDLE) && rst_n;
    collision = idle && !aw_held && !w_held && S_AXI_ARVALID &&
                (S_AXI_AWVALID || S_AXI_WVALID);
    // On a collision the write side yields unless the read won last time
    S_AXI_AWREADY = idle && !aw_held && !(collision && !rd_last);
    S_AXI_WREADY  = idle && !w_held  && !(collision && !rd_last);
    aw_hs         = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs          = S_AXI_WVALID  && S_AXI_WREADY;
    S_AXI_ARREADY = idle && !aw_held && !w_held && !aw_hs && !w_hs;
    ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;

    case (state)
      IDLE: begin
        if (ar_hs)
          state_nxt = RD;
        else if ((aw_held || aw_hs) && (w_held || w_hs))
          state_nxt = WR;
      end
      WR: begin
        valid = 1'b1;
        addr  = aw_addr_q;
        wdata = w_data_q;
        wstrb = w_strb_q;
        if (ready) state_nxt = WRESP;
      end
      WRESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) state_nxt = IDLE;
      end
      RD: begin
        valid = 1'b1;
        addr  = ar_addr_q;
        if (ready) state_nxt = RRESP;
      end
      RRESP: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axil2iob.sv
// Directed bench for axil2iob: a registered-ready native RAM (one wait state)
// sits behind the bridge; expectations are hand-derived constants.
module tb_axil2iob;

  logic        clk;
  logic        rst_n;
  logic [9:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY;
  logic        S_AXI_ARVALID, S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic        valid, ready;
  logic [9:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;

  int checks = 0;
  int failures = 0;

  axil2iob #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Native RAM: answers one edge after it sees valid, ready is a single pulse
  logic [31:0] mem [0:255];
  bit          ram_stall;
  logic [3:0]  last_wstrb;
  bit          log_wr [0:63];
  int          log_cnt = 0;

  always @(posedge clk) begin
    if (!ram_stall && valid === 1'b1 && ready !== 1'b1) begin
      ready <= 1'b1;
      rdata <= mem[addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[addr[9:2]][8*b +: 8] <= wdata[8*b +: 8];
    end else begin
      ready <= 1'b0;
      rdata <= 32'hBAD0_BAD0;
    end
  end

  always @(posedge clk) begin
    if (valid === 1'b1) last_wstrb <= wstrb;
    if (valid === 1'b1 && ready === 1'b1 && log_cnt < 64) begin
      log_wr[log_cnt] <= (wstrb != 4'h0);
      log_cnt <= log_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    bit awd, wd, bd, aw_now, w_now;
    int n;
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    awd = 0; wd = 0; bd = 0; n = 0;
    while (!bd && n < 40) begin
      @(negedge clk);
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      if (S_AXI_BVALID) begin
        chk("wr_bresp", S_AXI_BRESP, 2'b00);
        bd = 1;
      end
      step();
      if (aw_now) begin S_AXI_AWVALID = 1'b0; awd = 1; end
      if (w_now)  begin S_AXI_WVALID = 1'b0;  wd = 1;  end
      n++;
    end
    chk("wr_complete", {awd, wd, bd}, 3'b111);
  endtask

  task automatic do_read(input logic [9:0] a, output logic [31:0] d);
    bit ard, rd, ar_now;
    int n;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    ard = 0; rd = 0; n = 0; d = 'x;
    while (!rd && n < 40) begin
      @(negedge clk);
      ar_now = S_AXI_ARVALID && S_AXI_ARREADY;
      if (S_AXI_RVALID) begin
        chk("rd_rresp", S_AXI_RRESP, 2'b00);
        d = S_AXI_RDATA;
        rd = 1;
      end
      step();
      if (ar_now) begin S_AXI_ARVALID = 1'b0; ard = 1; end
      n++;
    end
    chk("rd_complete", {ard, rd}, 2'b11);
  endtask

  task automatic collide(input logic [9:0] ra, input logic [9:0] wa, input logic [31:0] wd,
                         output logic [31:0] rd_val);
    bit ar_now, aw_now, w_now, r_now, b_now, rdone, bdone;
    int n;
    S_AXI_ARADDR = ra; S_AXI_AWADDR = wa; S_AXI_WDATA = wd; S_AXI_WSTRB = 4'hF;
    S_AXI_ARVALID = 1'b1; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    rdone = 0; bdone = 0; n = 0; rd_val = 'x;
    while (!(rdone && bdone) && n < 60) begin
      @(negedge clk);
      ar_now = S_AXI_ARVALID && S_AXI_ARREADY;
      aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
      w_now  = S_AXI_WVALID && S_AXI_WREADY;
      r_now  = S_AXI_RVALID && S_AXI_RREADY;
      b_now  = S_AXI_BVALID && S_AXI_BREADY;
      if (r_now) rd_val = S_AXI_RDATA;
      step();
      if (ar_now) S_AXI_ARVALID = 1'b0;
      if (aw_now) S_AXI_AWVALID = 1'b0;
      if (w_now)  S_AXI_WVALID = 1'b0;
      if (r_now)  rdone = 1;
      if (b_now)  bdone = 1;
      n++;
    end
    chk("collide_complete", {rdone, bdone}, 2'b11);
  endtask

  initial begin
    logic [31:0] rv;
    int base, n;
    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_ARADDR = '0; S_AXI_AWPROT = 3'b010; S_AXI_ARPROT = 3'b101;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;

    // Reset with every request valid: no ready may rise, all outputs zero
    step(); step();
    chk("rst_awready", S_AXI_AWREADY, 1'b0);
    chk("rst_wready", S_AXI_WREADY, 1'b0);
    chk("rst_arready", S_AXI_ARREADY, 1'b0);
    chk("rst_outputs", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP, S_AXI_RRESP, valid},
        7'b0);
    chk("rst_rdata", S_AXI_RDATA, 32'h0);
    chk("rst_native", {addr, wdata, wstrb}, 46'h0);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("idle_awready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    // Single write with cycle-exact latency
    S_AXI_AWADDR = 10'h004; S_AXI_WDATA = 32'h0000_00A5; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    #1;
    chk("w1_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b110);
    step();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    chk("w1_native", {valid, addr, wdata, wstrb}, {1'b1, 10'h004, 32'h0000_00A5, 4'hF});
    chk("w1_busy_ready", {S_AXI_AWREADY, S_AXI_BVALID}, 2'b00);
    step();
    chk("w1_wait", {valid, S_AXI_BVALID}, 2'b10);
    step();
    chk("w1_bvalid", {valid, S_AXI_BVALID, S_AXI_BRESP}, 4'b0100);
    step();
    chk("w1_after_b", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b01);
    do_read(10'h004, rv);
    chk("w1_readback", rv, 32'h0000_00A5);

    // W four cycles ahead of AW
    S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    #1;
    chk("dec_wready", S_AXI_WREADY, 1'b1);
    step();
    S_AXI_WVALID = 1'b0;
    chk("dec_w_held", {S_AXI_WREADY, S_AXI_ARREADY, valid}, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dec_wait", {S_AXI_WREADY, valid}, 2'b00);
    end
    S_AXI_AWADDR = 10'h010; S_AXI_AWVALID = 1'b1;
    #1;
    chk("dec_awready", S_AXI_AWREADY, 1'b1);
    step();
    S_AXI_AWVALID = 1'b0;
    chk("dec_native", {valid, addr, wdata}, {1'b1, 10'h010, 32'hDEAD_BEEF});
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (S_AXI_BVALID) break;
      n++;
    end
    chk("dec_bvalid_seen", S_AXI_BVALID, 1'b1);
    step();
    do_read(10'h010, rv);
    chk("dec_readback", rv, 32'hDEAD_BEEF);

    // Partial strobe merges into existing word
    do_write(10'h020, 32'h1122_3344, 4'hF);
    do_write(10'h020, 32'h0000_00FF, 4'b0001);
    chk("part_native_wstrb", last_wstrb, 4'b0001);
    do_read(10'h020, rv);
    chk("part_readback", rv, 32'h1122_33FF);

    // Collisions right after reset: read wins first, then write wins
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    base = log_cnt;
    collide(10'h004, 10'h040, 32'h0000_0055, rv);
    chk("col1_order", {log_wr[base], log_wr[base+1]}, 2'b01);
    chk("col1_rdata", rv, 32'h0000_00A5);
    base = log_cnt;
    collide(10'h040, 10'h044, 32'h0000_0066, rv);
    chk("col2_order", {log_wr[base], log_wr[base+1]}, 2'b10);
    chk("col2_rdata", rv, 32'h0000_0055);

    // Read response backpressure
    do_write(10'h030, 32'h7, 4'hF);
    S_AXI_ARADDR = 10'h030; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
    #1;
    chk("bp_arready", S_AXI_ARREADY, 1'b1);
    step();
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (S_AXI_RVALID) break;
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {S_AXI_RVALID, S_AXI_ARREADY, S_AXI_RDATA}, {2'b10, 32'h7});
      step();
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    chk("bp_final", {S_AXI_RVALID, S_AXI_RDATA}, {1'b1, 32'h7});
    step();
    chk("bp_released", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);

    // Reset while the native read is outstanding
    ram_stall = 1'b1;
    S_AXI_ARADDR = 10'h030; S_AXI_ARVALID = 1'b1;
    step();
    S_AXI_ARVALID = 1'b0;
    step();
    chk("mid_rd_busy", {valid, addr}, {1'b1, 10'h030});
    rst_n = 1'b0;
    step();
    chk("mid_rd_reset", {valid, S_AXI_RVALID, S_AXI_ARREADY}, 3'b000);
    rst_n = 1'b1;
    ram_stall = 1'b0;
    do_read(10'h030, rv);
    chk("mid_rd_fresh", rv, 32'h7);

    // Stress: sequential writes then reads
    for (int i = 0; i < 10; i++) do_write(10'(4 * i), 32'(2 * i + 1), 4'hF);
    for (int i = 0; i < 10; i++) begin
      do_read(10'(4 * i), rv);
      chk("stress_read", rv, 32'(2 * i + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
